// File: rtl/shift_reg_arbiter_if.sv
// Bundle between the requesters, the arbiter and the shared 4-bit universal
// shift register. The arbiter uses the slave modport; the requester/shift
// register side uses master.
interface shift_reg_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0, req1;
  logic             dir0, dir1;
  logic [WIDTH-1:0] data0, data1;
  logic             grant0, grant1;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rx_word;
  logic [WIDTH-1:0] sr_D;
  logic             sr_load;
  logic             sr_l_r;
  logic             sr_S_in;
  logic             sr_S_out;

  modport slave (
    input  req0, req1, dir0, dir1, data0, data1, sr_S_out,
    output grant0, grant1, busy, done, rx_word, sr_D, sr_load, sr_l_r, sr_S_in
  );

  modport master (
    output req0, req1, dir0, dir1, data0, data1, sr_S_out,
    input  grant0, grant1, busy, done, rx_word, sr_D, sr_load, sr_l_r, sr_S_in
  );
endinterface

// File: rtl/shift_reg_arbiter.sv
// Two-requester arbiter/sequencer for a shared universal shift register.
// A granted word is parallel-loaded, shifted out serially in the requested
// direction, reassembled from S_out into rx_word, and reported with done.
// Build option: define SHIFT_ARB_FIXED_PRIO_EN for fixed priority (req0 wins);
// default is round-robin between the two requesters.
module shift_reg_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  shift_reg_arbiter_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] rx_word_q, rx_word_d;
  logic [WIDTH-1:0] sr_d_q, sr_d_d;
  logic             dir_q, dir_d;
  logic             owner_q, owner_d;
  logic             grant0_q, grant0_d, grant1_q, grant1_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             sr_load_q, sr_load_d, sr_l_r_q, sr_l_r_d;
  logic             shifting_d;
  logic             pick;

`ifdef SHIFT_ARB_FIXED_PRIO_EN
  // req0 always wins a tie; no history is kept.
  assign pick = ~bus.req0;
`else
  logic last_q, last_d;
  // On a tie the requester not served last wins; otherwise the lone requester.
  assign pick = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
`endif

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    dir_d     = dir_q;
    owner_d   = owner_q;
    rx_d      = rx_q;
    rx_word_d = rx_word_q;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
    last_d    = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          owner_d = pick;
          data_d  = pick ? bus.data1 : bus.data0;
          dir_d   = pick ? bus.dir1  : bus.dir0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        rx_d    = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // S_out is valid from the second shift cycle onward (registered in
        // the shift register), so the bit sampled at cnt=k is data bit k-1.
        if (cnt_q != '0)
          rx_d = dir_q ? {rx_q[WIDTH-2:0], bus.sr_S_out}
                       : {bus.sr_S_out, rx_q[WIDTH-1:1]};
        if (cnt_q == CW'(WIDTH)) begin
          rx_word_d = rx_d;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
`ifndef SHIFT_ARB_FIXED_PRIO_EN
        last_d  = owner_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    shifting_d = (state_d == S_SHIFT) && (cnt_d < CW'(WIDTH));
    grant0_d   = (state_d != S_IDLE) && !owner_d;
    grant1_d   = (state_d != S_IDLE) &&  owner_d;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    sr_load_d  = !shifting_d;
    sr_l_r_d   = shifting_d ? dir_d : 1'b0;
    sr_d_d     = (state_d == S_LOAD) ? data_d : '0;
  end

  // State and output registers; async reset returns everything to idle values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      dir_q     <= 1'b0;
      owner_q   <= 1'b0;
      rx_q      <= '0;
      rx_word_q <= '0;
      sr_d_q    <= '0;
      grant0_q  <= 1'b0;
      grant1_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sr_load_q <= 1'b1;
      sr_l_r_q  <= 1'b0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      dir_q     <= dir_d;
      owner_q   <= owner_d;
      rx_q      <= rx_d;
      rx_word_q <= rx_word_d;
      sr_d_q    <= sr_d_d;
      grant0_q  <= grant0_d;
      grant1_q  <= grant1_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sr_load_q <= sr_load_d;
      sr_l_r_q  <= sr_l_r_d;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  assign bus.grant0  = grant0_q;
  assign bus.grant1  = grant1_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_word = rx_word_q;
  assign bus.sr_D    = sr_d_q;
  assign bus.sr_load = sr_load_q;
  assign bus.sr_l_r  = sr_l_r_q;
  assign bus.sr_S_in = 1'b0;
endmodule

// File: tb/tb_shift_reg_arbiter.sv
// Bench for shift_reg_arbiter: a 4-bit universal shift register model closes
// the serial loop, a transaction-timeline model predicts every output each
// cycle, and directed scenarios pin the model with literal expectations.
module tb_shift_reg_arbiter;
  localparam int W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   cmp_en  = 1'b0;

  shift_reg_arbiter_if #(.WIDTH(W)) bus ();
  shift_reg_arbiter #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Shift register: load has priority, otherwise shift each clock; S_out
  // registers the bit that falls off the end.
  logic [W-1:0] sq;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sq <= '0;
      bus.sr_S_out <= 1'b0;
    end else if (bus.sr_load) begin
      sq <= bus.sr_D;
    end else if (bus.sr_l_r) begin
      bus.sr_S_out <= sq[W-1];
      sq <= {sq[W-2:0], bus.sr_S_in};
    end else begin
      bus.sr_S_out <= sq[0];
      sq <= {bus.sr_S_in, sq[W-1:1]};
    end
  end

  // Timeline model: t counts cycles since grant; t=0 load, t=1..W shifting,
  // t=W+1 halt/clear, t=W+2 done. rx_word becomes the granted word at done.
  bit           m_active = 0;
  int           m_t = 0;
  bit           m_owner = 0;
  bit           m_last = 1;
  bit           m_dir = 0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_rx = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0; m_t = 0; m_owner = 0; m_last = 1; m_dir = 0;
      m_data = '0; m_rx = '0;
    end else if (!m_active) begin
      if (bus.req0 || bus.req1) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
        m_owner = bus.req0 ? 1'b0 : 1'b1;
`else
        m_owner = (bus.req0 && bus.req1) ? !m_last : bus.req1;
`endif
        m_data   = m_owner ? bus.data1 : bus.data0;
        m_dir    = m_owner ? bus.dir1 : bus.dir0;
        m_active = 1;
        m_t      = 0;
      end
    end else if (m_t == W + 2) begin
      m_active = 0;
      m_last   = m_owner;
    end else begin
      m_t++;
      if (m_t == W + 2) m_rx = m_data;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("grant0", bus.grant0, m_active && !m_owner);
      chk("grant1", bus.grant1, m_active && m_owner);
      chk("busy", bus.busy, m_active);
      chk("done", bus.done, m_active && m_t == W + 2);
      chk("sr_load", bus.sr_load, !(m_active && m_t >= 1 && m_t <= W));
      chk("rx_word", bus.rx_word, m_rx);
      chk("sr_S_in", bus.sr_S_in, 1'b0);
      if (m_active && m_t >= 1 && m_t <= W) chk("sr_l_r", bus.sr_l_r, m_dir);
      if (!m_active || m_t == 0 || m_t == W + 1)
        chk("sr_D", bus.sr_D, (m_active && m_t == 0) ? m_data : '0);
    end
  end

  // Observation window bookkeeping for the directed scenarios.
  int           g0cnt, g1cnt, ldlow, done_k, g1_first;
  bit           lr_hi;
  logic [W-1:0] done_rx;
  int           dseq_g[$];
  logic [W-1:0] dseq_rx[$];

  // Steps n cycles sampling at the falling edge. Requests drop when done is
  // seen unless hold is set, and unconditionally after cycle drop_k.
  task automatic obs(input int n, input int drop_k, input bit hold);
    g0cnt = 0; g1cnt = 0; ldlow = 0; done_k = -1; g1_first = -1; lr_hi = 0;
    done_rx = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (bus.grant0) g0cnt++;
      if (bus.grant1) begin
        g1cnt++;
        if (g1_first < 0) g1_first = k;
      end
      if (!bus.sr_load) begin
        ldlow++;
        if (bus.sr_l_r) lr_hi = 1;
      end
      if (bus.done) begin
        if (done_k < 0) begin
          done_k  = k;
          done_rx = bus.rx_word;
        end
        dseq_g.push_back(bus.grant1 ? 1 : 0);
        dseq_rx.push_back(bus.rx_word);
        if (!hold) begin bus.req0 = 0; bus.req1 = 0; end
      end
      if (k == drop_k) begin bus.req0 = 0; bus.req1 = 0; end
    end
  endtask

  int           exp_g[4];
  logic [W-1:0] exp_rx[4];

  initial begin
    bus.req0 = 0; bus.req1 = 0; bus.dir0 = 0; bus.dir1 = 0;
    bus.data0 = '0; bus.data1 = '0;
    @(posedge clk);
    cmp_en = 1;
    @(negedge clk);
    chk("rst_grant0", bus.grant0, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_sr_load", bus.sr_load, 1'b1);
    chk("rst_sr_l_r", bus.sr_l_r, 1'b0);
    chk("rst_rx_word", bus.rx_word, '0);
    reset = 0;
    @(negedge clk);

    // Single left transaction from requester 0.
    bus.req0 = 1; bus.dir0 = 1; bus.data0 = 4'b1011;
    obs(9, -1, 0);
    chk("left_grant_cycles", g0cnt, 7);
    chk("left_done_at", done_k, 7);
    chk("left_rx", done_rx, 4'b1011);
    chk("left_load_low", ldlow, 4);

    // Single right transaction from requester 1.
    bus.req1 = 1; bus.dir1 = 0; bus.data1 = 4'b0110;
    obs(9, -1, 0);
    chk("right_grant_cycles", g1cnt, 7);
    chk("right_done_at", done_k, 7);
    chk("right_rx", done_rx, 4'b0110);
    chk("right_lr_low", lr_hi, 1'b0);

    // Request dropped after one granted cycle still completes; nothing follows.
    bus.req0 = 1; bus.dir0 = 0; bus.data0 = 4'b1110;
    obs(12, 1, 0);
    chk("drop_done_at", done_k, 7);
    chk("drop_rx", done_rx, 4'b1110);
    chk("drop_grant_cycles", g0cnt, 7);
    chk("drop_no_grant1", g1cnt, 0);

    // Reset in SHIFT with cnt=2, then a pending req1 is granted first.
    bus.req0 = 1; bus.dir0 = 1; bus.data0 = 4'b1001;
    obs(4, -1, 0);
    bus.req0 = 0; bus.req1 = 1; bus.dir1 = 0; bus.data1 = 4'b0101;
    #1 reset = 1;
    #1;
    chk("midrst_grant0", bus.grant0, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_sr_load", bus.sr_load, 1'b1);
    chk("midrst_sr_D", bus.sr_D, '0);
    chk("midrst_rx", bus.rx_word, '0);
    @(negedge clk);
    reset = 0;
    obs(9, -1, 0);
    chk("postrst_grant1_first", g1_first, 1);
    chk("postrst_done_at", done_k, 7);
    chk("postrst_rx", done_rx, 4'b0101);

    // Both requests held for four transactions.
    dseq_g.delete(); dseq_rx.delete();
    bus.req0 = 1; bus.req1 = 1; bus.dir0 = 1; bus.dir1 = 0;
    bus.data0 = 4'h3; bus.data1 = 4'hC;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    exp_g  = '{0, 0, 0, 0};
    exp_rx = '{4'h3, 4'h3, 4'h3, 4'h3};
`else
    exp_g  = '{0, 1, 0, 1};
    exp_rx = '{4'h3, 4'hC, 4'h3, 4'hC};
`endif
    obs(32, 32, 1);
    chk("sim_done_count", dseq_g.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (dseq_g.size() > i) begin
        chk("sim_grant_order", dseq_g[i], exp_g[i]);
        chk("sim_rx_order", dseq_rx[i], exp_rx[i]);
      end
    end
    obs(4, -1, 0);
    chk("sim_idle_after", g0cnt + g1cnt, 0);

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_reg_arbiter.md
# shift_reg_arbiter

Sequencer and arbiter that shares one 4-bit universal shift register (parallel load, left/right serial shift, serial out) between two requesters. It grants one requester at a time and loads that requester's word into the register. It then shifts the word out serially in the requested direction, reassembles the serial bits into `rx_word`, and signals `done`. It sits between the requester logic and the shift register instance and is the only driver of the register's `load`, `l_r`, `D` and `S_in` inputs.

## Interface
- `WIDTH`, default 4: bits shifted per transaction. Must equal the shift register width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req0`, `req1`  in  1  transaction requests. Held high until the matching `done`.
- `dir0`, `dir1`  in  1  shift direction per requester: 1 = left (MSB out first), 0 = right (LSB out first).
- `data0`, `data1`  in  WIDTH  parallel word per requester.
- `grant0`, `grant1`  out  1  owner of the shift register; at most one high.
- `busy`  out  1  transaction in progress (any state other than IDLE).
- `done`  out  1  one-cycle pulse at end of transaction.
- `rx_word`  out  WIDTH  serial stream reassembled; valid while `done` is high, held until the next DONE.
- `sr_D`  out  WIDTH  to shift register `D`.
- `sr_load`  out  1  to shift register `load`.
- `sr_l_r`  out  1  to shift register `l_r`.
- `sr_S_in`  out  1  to shift register `S_in`; constant 0.
- `sr_S_out`  in  1  from shift register `S_out`.

## Operation
- Reset values: `grant0`=`grant1`=0, `busy`=0, `done`=0, `rx_word`=0, `sr_load`=1, `sr_D`=0, `sr_l_r`=0, `sr_S_in`=0. State is IDLE, the round-robin pointer favours `req0`, and the bit counter is 0.
- The shift register shifts on every clock when `load`=0. The controller therefore holds `sr_load`=1 in every state except SHIFT with `cnt`<WIDTH.
- States:
  - IDLE: `sr_load`=1, `sr_D`=0.
    - If `req0` or `req1` is high, pick the winner and latch its data and direction into internal registers. Set the winner's grant and go to LOAD.
    - Only one request: it wins. Both requests: the requester not served last wins.
  - LOAD: `sr_load`=1, `sr_D`=latched data. Clear `cnt`, go to SHIFT.
  - SHIFT (`cnt` = 0..WIDTH):
    - For `cnt`<WIDTH: `sr_load`=0, `sr_l_r`=latched direction.
    - For `cnt`=WIDTH: `sr_load`=1, `sr_D`=0, which halts and clears the register.
    - For `cnt`>=1, sample `sr_S_out` into the rx shifter. Left: `rx={rx[WIDTH-2:0],bit}`. Right: `rx={bit,rx[WIDTH-1:1]}`.
    - At `cnt`=WIDTH, go to DONE.
  - DONE: `done`=1, `rx_word`=rx shifter, grant still high. Update the round-robin pointer to the served requester, then go to IDLE, where the grant drops.
- Arithmetic: `cnt` is $clog2(WIDTH+1) bits and never wraps.
- `rx_word` equals the latched data for both directions; this loopback identity is the functional invariant.
- A request dropped mid-transaction is ignored: the transaction completes and `done` still pulses.
- A request arriving while busy waits. It is sampled only in IDLE.
- The served requester may re-request immediately. If the other requester is already waiting, it wins the next arbitration (round-robin).
- Reset asserted mid-transaction: immediately return to the reset values. No `done`, and the partial `rx_word` is discarded.

## Timing
- Request sampled at edge E0 in IDLE: grant is high from E0 until E0+WIDTH+3.
- LOAD occupies [E0,E1). SHIFT occupies [E1,E1+WIDTH+1). DONE occupies [E0+WIDTH+2, E0+WIDTH+3).
- `done` is high in the single cycle starting at E0+WIDTH+2 (E0+6 for WIDTH=4).
- Back-to-back transactions: the next grant begins at E0+WIDTH+4, so one IDLE cycle separates transactions. Throughput is one word per WIDTH+4 cycles.
- All outputs are decoded from registered state. No combinational path from `req*` to any output.

## Configuration
- `SHIFT_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. When both requests are high in IDLE, `req0` always wins and the round-robin pointer is not implemented.
  - Undefined (default): round-robin as in Operation.

## Test plan
- Reset mid-SHIFT (`cnt`=2): all outputs return to reset values within the reset cycle, with no `done`. After release, a pending `req1` is granted in the first IDLE.
- Single left transaction: `req0`=1, `dir0`=1, `data0`=4'b1011 → `grant0` high for 7 cycles. `done` pulses at E0+6, `rx_word`=4'b1011, and `sr_load` is low for exactly 4 cycles.
- Single right transaction: `req1`=1, `dir1`=0, `data1`=4'b0110 → `grant1` high, `done` at E0+6, `rx_word`=4'b0110. `sr_l_r` is 0 during SHIFT.
- Simultaneous requests held high (`data0`=4'h3, `data1`=4'hC) → grants alternate 0,1,0,1 and `rx_word` alternates 3,C. With `SHIFT_ARB_FIXED_PRIO_EN` defined, only `grant0` is ever issued.
- Request dropped after one cycle of `grant0` → the transaction still completes with `done` at E0+6. No new grant follows unless a request is high in IDLE.
